// File: rtl/robo_coletor_ctrl.sv
// Wall-following collector robot controller.
// One registered action per cycle (forward / turn / remove / standby), chosen from
// the head/left/under/barrier sensors. Rotation toward the wall and multi-unit
// debris removal run as uninterruptible sequences. A move budget, an optional dock
// stop and a turn-streak stuck detector park the robot in sticky standby states.
module robo_coletor_ctrl #(
  parameter int MAX_LIXO      = 3,
  parameter int SIZE_W        = 2,
  parameter int MOVE_W        = 8,
  parameter int MOVE_BUDGET   = 200,
  parameter int STUCK_LIMIT   = 8,
  parameter int TURNS_TO_WALL = 3,
  parameter int STOP_ON_UNDER = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  input  logic [SIZE_W-1:0] lixo_size,
  output logic              forward,
  output logic              turn,
  output logic              remove,
  output logic              standby,
  output logic [MOVE_W-1:0] move_count,
  output logic              stuck,
  output logic              done
);

  localparam logic [2:0] ST_SEARCH = 3'd0;
  localparam logic [2:0] ST_FOLLOW = 3'd1;
  localparam logic [2:0] ST_ROT    = 3'd2;
  localparam logic [2:0] ST_FWD1   = 3'd3;
  localparam logic [2:0] ST_REM    = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;
  localparam logic [2:0] ST_STUCK  = 3'd6;

  localparam int STREAK_W = $clog2(STUCK_LIMIT + 1);
  localparam int ROT_W    = $clog2(TURNS_TO_WALL + 1);

  localparam logic [MOVE_W-1:0]   BUDGET_V = MOVE_W'(MOVE_BUDGET);
  localparam logic [STREAK_W-1:0] LIMIT_V  = STREAK_W'(STUCK_LIMIT);
  localparam logic [ROT_W-1:0]    ROT_V    = ROT_W'(TURNS_TO_WALL);
  localparam logic [SIZE_W-1:0]   MAX_V    = SIZE_W'(MAX_LIXO);
  localparam logic [SIZE_W-1:0]   ONE_SZ   = SIZE_W'(1);
  localparam logic [ROT_W-1:0]    ONE_ROT  = ROT_W'(1);

  logic [2:0]          state_q, state_d;
  logic                forward_q, forward_d;
  logic                turn_q, turn_d;
  logic                remove_q, remove_d;
  logic                standby_q, standby_d;
  logic [MOVE_W-1:0]   move_count_q, move_count_d;
  logic                stuck_q, stuck_d;
  logic                done_q, done_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ROT_W-1:0]    rot_cnt_q, rot_cnt_d;
  logic [SIZE_W-1:0]   rem_left_q, rem_left_d;
  logic                ret_follow_q, ret_follow_d;  // REM returns to FOLLOW when set

  logic [SIZE_W-1:0]   size_s;
  logic [ROT_W-1:0]    rot_next_s;
  logic                halt_now_s;
  logic                act_s;

  assign forward    = forward_q;
  assign turn       = turn_q;
  assign remove     = remove_q;
  assign standby    = standby_q;
  assign move_count = move_count_q;
  assign stuck      = stuck_q;
  assign done       = done_q;

  // Normalise the debris size: zero counts as one unit, oversize clamps to the maximum.
  always_comb begin
    size_s = lixo_size;
    if (lixo_size == {SIZE_W{1'b0}}) begin
      size_s = ONE_SZ;
    end else if (lixo_size > MAX_V) begin
      size_s = MAX_V;
    end else begin
      size_s = lixo_size;
    end
  end

  // Next-state and next-action decision; halts are only evaluated outside ROT/REM.
  always_comb begin
    state_d      = state_q;
    forward_d    = 1'b0;
    turn_d       = 1'b0;
    remove_d     = 1'b0;
    standby_d    = 1'b0;
    stuck_d      = stuck_q;
    done_d       = done_q;
    rot_cnt_d    = rot_cnt_q;
    rem_left_d   = rem_left_q;
    ret_follow_d = ret_follow_q;
    rot_next_s   = rot_cnt_q + ONE_ROT;
    halt_now_s   = (move_count_q == BUDGET_V) || ((STOP_ON_UNDER != 0) && under);
    case (state_q)
      ST_SEARCH, ST_FOLLOW, ST_FWD1: begin
        if (halt_now_s) begin
          state_d   = ST_HALT;
          standby_d = 1'b1;
          done_d    = 1'b1;
        end else if (streak_q == LIMIT_V) begin
          state_d   = ST_STUCK;
          standby_d = 1'b1;
          stuck_d   = 1'b1;
        end else if (barrier) begin
          // Entry cycle already issues the first remove.
          remove_d     = 1'b1;
          rem_left_d   = size_s - ONE_SZ;
          ret_follow_d = (state_q != ST_SEARCH);
          if (size_s == ONE_SZ) begin
            state_d = (state_q != ST_SEARCH) ? ST_FOLLOW : ST_SEARCH;
          end else begin
            state_d = ST_REM;
          end
        end else if ((state_q == ST_SEARCH) && !left) begin
          state_d   = ST_SEARCH;
          turn_d    = head;
          forward_d = !head;
        end else if ((state_q == ST_FOLLOW) && !left) begin
          // Wall lost: start rotating back toward it.
          turn_d    = 1'b1;
          rot_cnt_d = ONE_ROT;
          state_d   = (ONE_ROT >= ROT_V) ? ST_FWD1 : ST_ROT;
        end else begin
          // FOLLOW rules; also covers SEARCH finding the wall and the FWD1 step.
          state_d   = ST_FOLLOW;
          turn_d    = head;
          forward_d = !head;
        end
      end
      ST_ROT: begin
        turn_d    = 1'b1;
        rot_cnt_d = rot_next_s;
        if (rot_next_s >= ROT_V) begin
          state_d = ST_FWD1;
        end else begin
          state_d = ST_ROT;
        end
      end
      ST_REM: begin
        remove_d   = 1'b1;
        rem_left_d = rem_left_q - ONE_SZ;
        if (rem_left_q <= ONE_SZ) begin
          state_d = ret_follow_q ? ST_FOLLOW : ST_SEARCH;
        end else begin
          state_d = ST_REM;
        end
      end
      ST_HALT: begin
        standby_d = 1'b1;
        done_d    = 1'b1;
      end
      ST_STUCK: begin
        standby_d = 1'b1;
        stuck_d   = 1'b1;
      end
      default: begin
        state_d   = ST_SEARCH;
        standby_d = 1'b1;
      end
    endcase
  end

  // Saturating move counter and turn-streak counter driven by the chosen action.
  always_comb begin
    act_s        = forward_d | turn_d | remove_d;
    move_count_d = move_count_q;
    streak_d     = streak_q;
    if (act_s && (move_count_q != BUDGET_V)) begin
      move_count_d = move_count_q + MOVE_W'(1);
    end else begin
      move_count_d = move_count_q;
    end
    if (forward_d || remove_d) begin
      streak_d = {STREAK_W{1'b0}};
    end else if (turn_d && (streak_q != LIMIT_V)) begin
      streak_d = streak_q + STREAK_W'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  // State and registered outputs; reset aborts any sequence in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      forward_q    <= 1'b0;
      turn_q       <= 1'b0;
      remove_q     <= 1'b0;
      standby_q    <= 1'b1;
      move_count_q <= {MOVE_W{1'b0}};
      stuck_q      <= 1'b0;
      done_q       <= 1'b0;
      streak_q     <= {STREAK_W{1'b0}};
      rot_cnt_q    <= {ROT_W{1'b0}};
      rem_left_q   <= {SIZE_W{1'b0}};
      ret_follow_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      forward_q    <= forward_d;
      turn_q       <= turn_d;
      remove_q     <= remove_d;
      standby_q    <= standby_d;
      move_count_q <= move_count_d;
      stuck_q      <= stuck_d;
      done_q       <= done_d;
      streak_q     <= streak_d;
      rot_cnt_q    <= rot_cnt_d;
      rem_left_q   <= rem_left_d;
      ret_follow_q <= ret_follow_d;
    end
  end

endmodule

// File: tb/tb_robo_coletor_ctrl.sv
// Scoreboard bench for robo_coletor_ctrl: two instances (default and a tight
// configuration) share the sensor stimulus; a behavioural model predicts actions.
module tb_robo_coletor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
  logic [1:0] lixo_size = 2'd0;

  logic       fwd0, trn0, rem0, stb0, stk0, dn0;
  logic       fwd1, trn1, rem1, stb1, stk1, dn1;
  logic [7:0] mc0, mc1;

  always #5 clk = ~clk;

  robo_coletor_ctrl dut0 (
    .clock(clk), .reset(reset), .head(head), .left(left), .under(under),
    .barrier(barrier), .lixo_size(lixo_size), .forward(fwd0), .turn(trn0),
    .remove(rem0), .standby(stb0), .move_count(mc0), .stuck(stk0), .done(dn0)
  );

  robo_coletor_ctrl #(
    .MAX_LIXO(3), .SIZE_W(2), .MOVE_W(8), .MOVE_BUDGET(12), .STUCK_LIMIT(4),
    .TURNS_TO_WALL(2), .STOP_ON_UNDER(1)
  ) dut1 (
    .clock(clk), .reset(reset), .head(head), .left(left), .under(under),
    .barrier(barrier), .lixo_size(lixo_size), .forward(fwd1), .turn(trn1),
    .remove(rem1), .standby(stb1), .move_count(mc1), .stuck(stk1), .done(dn1)
  );

  // configuration of each instance as seen by the model
  function automatic int p_bud(int k);   return (k == 0) ? 200 : 12; endfunction
  function automatic int p_lim(int k);   return (k == 0) ? 8 : 4;    endfunction
  function automatic int p_ttw(int k);   return (k == 0) ? 3 : 2;    endfunction
  function automatic bit p_sou(int k);   return (k == 0) ? 1'b0 : 1'b1; endfunction
  localparam int MAXL = 3;

  // action codes: 0 standby, 1 forward, 2 turn, 3 remove
  int m_moves[2], m_streak[2], m_act[2], m_plan_n[2], m_plan_act[2];
  bit m_follow[2], m_afterrot[2], m_done[2], m_stuck[2];

  typedef struct {
    int act0; int act1;
    int mc0;  int mc1;
    bit st0;  bit st1;
    bit dn0;  bit dn1;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  task automatic model_reset(input int k);
    m_moves[k] = 0; m_streak[k] = 0; m_act[k] = 0; m_plan_n[k] = 0; m_plan_act[k] = 0;
    m_follow[k] = 1'b0; m_afterrot[k] = 1'b0; m_done[k] = 1'b0; m_stuck[k] = 1'b0;
  endtask

  task automatic model_step(input int k, input bit h, input bit l, input bit u,
                            input bit b, input int sz);
    int a;
    int n;
    a = 0;
    if (m_done[k] || m_stuck[k]) begin
      a = 0;
    end else if (m_plan_n[k] > 0) begin
      a = m_plan_act[k];
      m_plan_n[k] = m_plan_n[k] - 1;
    end else if ((m_moves[k] == p_bud(k)) || (p_sou(k) && u)) begin
      m_done[k] = 1'b1;
    end else if (m_streak[k] == p_lim(k)) begin
      m_stuck[k] = 1'b1;
    end else if (b) begin
      n = (sz == 0) ? 1 : ((sz > MAXL) ? MAXL : sz);
      a = 3;
      m_plan_act[k] = 3;
      m_plan_n[k] = n - 1;
      m_afterrot[k] = 1'b0;
    end else if (m_afterrot[k]) begin
      m_afterrot[k] = 1'b0;
      m_follow[k] = 1'b1;
      a = h ? 2 : 1;
    end else if (!l && !m_follow[k]) begin
      a = h ? 2 : 1;
    end else if (!l) begin
      a = 2;
      m_plan_act[k] = 2;
      m_plan_n[k] = p_ttw(k) - 1;
      m_afterrot[k] = 1'b1;
    end else begin
      m_follow[k] = 1'b1;
      a = h ? 2 : 1;
    end
    if (a != 0 && m_moves[k] < p_bud(k)) m_moves[k] = m_moves[k] + 1;
    if (a == 1 || a == 3) m_streak[k] = 0;
    else if (a == 2 && m_streak[k] < p_lim(k)) m_streak[k] = m_streak[k] + 1;
    m_act[k] = a;
  endtask

  // Apply one cycle of stimulus and queue the predicted response of both instances.
  task automatic drive(input bit r, input bit h, input bit l, input bit u,
                       input bit b, input int sz);
    exp_t e;
    @(negedge clk);
    reset = r; head = h; left = l; under = u; barrier = b; lixo_size = 2'(sz);
    for (int k = 0; k < 2; k++) begin
      if (r) model_reset(k);
      else model_step(k, h, l, u, b, sz);
    end
    e.act0 = m_act[0];   e.act1 = m_act[1];
    e.mc0  = m_moves[0]; e.mc1  = m_moves[1];
    e.st0  = m_stuck[0]; e.st1  = m_stuck[1];
    e.dn0  = m_done[0];  e.dn1  = m_done[1];
    sbq.push_back(e);
  endtask

  function automatic int code_of(logic f, logic t, logic rm, logic s);
    int c;
    case ({f, t, rm, s})
      4'b0001: c = 0;
      4'b1000: c = 1;
      4'b0100: c = 2;
      4'b0010: c = 3;
      default: c = -1;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("act0",   code_of(fwd0, trn0, rem0, stb0), e.act0);
        chk("mc0",    int'(mc0), e.mc0);
        chk("stuck0", int'(stk0), int'(e.st0));
        chk("done0",  int'(dn0), int'(e.dn0));
        chk("act1",   code_of(fwd1, trn1, rem1, stb1), e.act1);
        chk("mc1",    int'(mc1), e.mc1);
        chk("stuck1", int'(stk1), int'(e.st1));
        chk("done1",  int'(dn1), int'(e.dn1));
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run with sporadic resets.
  initial begin
    bit r, h, l, u, b;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    // open field: budget exhaustion on both instances
    for (int i = 0; i < 210; i++) drive(0, 0, 0, 0, 0, 0);
    // search turns, find wall, lose wall -> rotation, then follow
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0);
    // debris of size 3 (barrier held), 0 and 2
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 3);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 1, 0, 1, 2);
    drive(0, 0, 1, 0, 0, 0);
    // head and wall constantly present -> stuck
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(0, 1, 1, 0, 0, 0);
    // dock marker on cycle 2
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // reset in the middle of a rotation
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // reset in the middle of a removal
    drive(0, 0, 0, 0, 1, 3);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // randomized run
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(99, 0) < 2);
      h = ($urandom_range(99, 0) < 35);
      l = ($urandom_range(99, 0) < 60);
      u = ($urandom_range(99, 0) < 3);
      b = ($urandom_range(99, 0) < 15);
      drive(r, h, l, u, b, int'($urandom_range(3, 0)));
    end
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/robo_coletor_ctrl.md
Name: robo_coletor_ctrl

Overview:
- Parametrised successor to the Robo collector controller.
- Registered FSM that drives a grid robot along a wall on one side, using the head/left/under/barrier sensors. Wall side is a parameter; the sensor named "left" always means the followed-wall sensor.
- Adds features the first controller lacks: multi-unit debris removal, a move budget, stuck detection, dock-stop mode, and a standby output.
- Sits between the map/sensor model (testbench or sensor front-end) and the motion actuators.

Parameters:
- MAX_LIXO, 3: largest debris size; one remove pulse per unit.
- SIZE_W, 2: width of lixo_size; must satisfy 2^SIZE_W > MAX_LIXO.
- MOVE_W, 8: width of move_count.
- MOVE_BUDGET, 200: number of actions after which the robot halts.
- STUCK_LIMIT, 8: consecutive turn cycles with no forward or remove before declaring stuck.
- TURNS_TO_WALL, 3: turn pulses that make up a 90° rotation toward the wall (turn only rotates away from the wall).
- STOP_ON_UNDER, 0: 1 = halt when under=1; 0 = under is ignored.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- head  in  1  obstacle directly ahead.
- left  in  1  wall present on the followed side.
- under  in  1  dock marker beneath the robot.
- barrier  in  1  debris directly ahead.
- lixo_size  in  SIZE_W  size of debris ahead; valid when barrier=1.
- forward  out  1  advance one cell this cycle.
- turn  out  1  rotate 90° away from the wall this cycle.
- remove  out  1  remove one debris unit this cycle.
- standby  out  1  no action this cycle.
- move_count  out  MOVE_W  actions issued since reset.
- stuck  out  1  sticky stuck flag.
- done  out  1  sticky halt flag (budget reached or docked).

Behaviour:
- One clock, asynchronous active-high reset. All outputs are registered.
- Exactly one of forward/turn/remove/standby is high every cycle.
- Reset values: standby=1; forward, turn, remove = 0; move_count=0; stuck=0; done=0; state=SEARCH; internal counters = 0.
- Sensors are sampled on the rising edge. The action is visible from that edge for one cycle (latency 1). The environment updates sensors before the next rising edge.
- Halt priority, checked every cycle except inside ROT and REM:
  - move_count==MOVE_BUDGET, or (STOP_ON_UNDER and under) → HALT.
  - Turn-streak counter reaches STUCK_LIMIT → STUCK.
- SEARCH:
  - barrier → REM.
  - Else if left → FOLLOW, and decide in the same cycle using FOLLOW rules.
  - Else if head → turn.
  - Else → forward.
- FOLLOW:
  - barrier → REM.
  - Else if !left → ROT: issue a turn this cycle, with rot_cnt=1.
  - Else if head → turn.
  - Else → forward.
- ROT:
  - Issue turn each cycle until rot_cnt reaches TURNS_TO_WALL, then go to FWD1.
  - Sensors are ignored in ROT.
- FWD1:
  - barrier → REM.
  - Else if head → turn, go to FOLLOW.
  - Else → forward, go to FOLLOW.
- REM:
  - On entry, latch size = lixo_size, where 0 is treated as 1 and values above MAX_LIXO are clamped to MAX_LIXO.
  - Issue one remove per cycle for size cycles. The entry cycle issues the first remove.
  - barrier and lixo_size are ignored while in REM.
  - Afterwards, return to the state that entered REM (SEARCH or FOLLOW; FWD1 returns to FOLLOW).
- HALT: standby=1 and done=1 until reset.
- STUCK: standby=1 and stuck=1 until reset.
- Halts reached inside ROT or REM are deferred until the sequence completes. move_count saturates at MOVE_BUDGET.
- move_count increments on every forward, turn and remove.
- Turn-streak counter: cleared by forward or remove, incremented by turn (ROT turns included), saturates at STUCK_LIMIT.
- Reset asserted mid-ROT or mid-REM aborts the sequence immediately and restores all reset values.

Test Plan:
- Reset mid-run, then release with head=0, left=0, barrier=0 → standby=1 during reset; forward on every cycle afterwards; move_count increments by 1 per cycle.
- SEARCH with head=1, left=0 for 2 cycles, then left=1, head=0 → turn, turn, forward; state=FOLLOW.
- FOLLOW with left dropping to 0 (TURNS_TO_WALL=3, head=0) → turn ×3, then forward, then normal following resumes.
- barrier=1 with lixo_size=3, then 0, then 2 → remove ×3 / ×1 / ×2; barrier held high during REM causes no extra removes; move_count +3 / +1 / +2.
- head=1 and left=1 held constantly (STUCK_LIMIT=8) → 8 turns, then standby=1, stuck=1, which persist until reset.
- MOVE_BUDGET=5 with an open field → 5 forwards, then standby=1, done=1, move_count=5. Separately, STOP_ON_UNDER=1 with under=1 on cycle 2 → done=1 from cycle 2.
